// File: rtl/jtoutrun_obj_scan.sv
// jtoutrun_obj_scan
// Object table scanner for the double-buffered OutRun object RAM.
// Owns the bank select `half` (CPU side uses half, video side uses ~half) and
// swaps it at vblank when the CPU has asked for it. For every line it walks the
// video-side bank and hands each entry visible on that line to the draw engine.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   swap_req, vb_start    buffer-swap request pulse, vblank start pulse
//   hstart, vrender       start scanning for line vrender (sampled at hstart)
//   half                  bank select
//   tbl_addr, tbl_dout    bank-relative word address / registered read data (1-cycle latency)
//   dr_start, dr_busy     draw engine handshake
//   dr_idx, dr_line, dr_attr  entry index, line within object, words {w5,w4,w3,w2}
//   scan_ovf              pulse when a scan is cut short by a new hstart
//
// state | meaning
// IDLE  | waiting for hstart
// RD0   | w0 address on the bus, waiting for RAM latency
// CHK0  | w0 on tbl_dout: end / hide / latch top
// CHK1  | w1 on tbl_dout: visibility test against bottom
// FETCH | four cycles collecting w2..w5
// EMIT  | waiting for the draw engine to go idle, then hand over
// NEXT  | advance to the next entry or finish
// DONE  | one cycle before returning to IDLE
module jtoutrun_obj_scan #(
  parameter int MAXOBJ = 128,
  parameter int TOPW   = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            swap_req,
  input  logic            vb_start,
  input  logic            hstart,
  input  logic [TOPW-1:0] vrender,
  output logic            half,
  output logic [9:0]      tbl_addr,
  input  logic [15:0]     tbl_dout,
  output logic            dr_start,
  input  logic            dr_busy,
  output logic [6:0]      dr_idx,
  output logic [TOPW-1:0] dr_line,
  output logic [63:0]     dr_attr,
  output logic            scan_ovf
);

  typedef enum logic [2:0] {IDLE, RD0, CHK0, CHK1, FETCH, EMIT, NEXT, DONE} state_t;

  state_t          state;
  logic            pending;
  logic [6:0]      idx;
  logic [TOPW-1:0] vr;
  logic [TOPW-1:0] top;
  logic [63:0]     attr;
  logic [1:0]      fcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      half    <= 1'b0;
      pending <= 1'b0;
    end else if (vb_start && (pending || swap_req)) begin
      half    <= ~half;
      pending <= 1'b0;
    end else if (swap_req) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      vr       <= '0;
      top      <= '0;
      attr     <= '0;
      fcnt     <= '0;
      tbl_addr <= '0;
      dr_start <= 1'b0;
      dr_idx   <= '0;
      dr_line  <= '0;
      dr_attr  <= '0;
      scan_ovf <= 1'b0;
    end else begin
      dr_start <= 1'b0;
      scan_ovf <= 1'b0;
      // A new line always wins; any entry waiting in EMIT is dropped.
      if (hstart) begin
        if (state != IDLE && state != DONE) scan_ovf <= 1'b1;
        idx      <= '0;
        tbl_addr <= '0;
        vr       <= vrender;
        state    <= RD0;
      end else begin
        case (state)
          IDLE: ;
          RD0: begin
            tbl_addr <= tbl_addr + 10'd1;
            state    <= CHK0;
          end
          CHK0: begin
            if (tbl_dout[15]) begin
              state <= DONE;
            end else if (tbl_dout[14]) begin
              state <= NEXT;
            end else begin
              top      <= tbl_dout[TOPW-1:0];
              tbl_addr <= tbl_addr + 10'd1;
              state    <= CHK1;
            end
          end
          CHK1: begin
            if (top <= vr && vr < tbl_dout[TOPW-1:0]) begin
              tbl_addr <= tbl_addr + 10'd1;
              fcnt     <= '0;
              state    <= FETCH;
            end else begin
              state <= NEXT;
            end
          end
          FETCH: begin
            // Shift in from the top so w2 ends up in the low word.
            attr <= {tbl_dout, attr[63:16]};
            fcnt <= fcnt + 2'd1;
            if (fcnt < 2'd2) tbl_addr <= tbl_addr + 10'd1;
            if (fcnt == 2'd3) state <= EMIT;
          end
          EMIT: begin
            if (!dr_busy) begin
              dr_start <= 1'b1;
              dr_idx   <= idx;
              dr_line  <= vr - top;
              dr_attr  <= attr;
              state    <= NEXT;
            end
          end
          NEXT: begin
            if (idx == 7'(MAXOBJ - 1)) begin
              state <= DONE;
            end else begin
              idx      <= idx + 7'd1;
              tbl_addr <= {idx + 7'd1, 3'd0};
              state    <= RD0;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
